// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: opcodes, branch funct3 codes, reset defaults.
package fetch_unit_pkg;

    // Major opcodes (instr[6:0]) consumed by the control FSM
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // B-type funct3 encodings; 010/011 are unassigned and never taken
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct_t;

    // Reset defaults for the PC and the IR (addi x0,x0,0)
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_branch_cmp.sv
// Branch condition evaluator: decides whether a B-type instruction is taken.
module branch_cmp
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic            take
);

    // Select the comparison named by funct3; unassigned codes are never taken
    always_comb begin
        take = 1'b0;
        case (funct3)
            BEQ:     take = (rs1v == rs2v);
            BNE:     take = (rs1v != rs2v);
            BLT:     take = ($signed(rs1v) <  $signed(rs2v));
            BGE:     take = ($signed(rs1v) >= $signed(rs2v));
            BLTU:    take = (rs1v <  rs2v);
            BGEU:    take = (rs1v >= rs2v);
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// PC / PC_OLD / IR stage of the multicycle RV32I core with local branch resolution.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEFAULT_RESET_PC),
    parameter logic [31:0]      NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_en,
    input  logic            pc_update,
    input  logic            branch,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_old,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            instr_valid,
    output logic            branch_taken,
    output logic            misalign_err
);

    logic            cond_true;
    logic            pc_load;
    logic [XLEN-1:0] pc_src;

    // Decoded fields always follow the IR
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .funct3 (funct3),
        .rs1v   (rs1v),
        .rs2v   (rs2v),
        .take   (cond_true)
    );

    // PC source select: branch owns the PC write port, pc_update only when no branch
    always_comb begin
        branch_taken = branch & cond_true;
        pc_load      = branch ? cond_true : pc_update;
        pc_src       = branch ? branch_target : result;
    end

    // PC, PC_OLD, IR and status flags; PC loads are word-aligned and flag misalignment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            pc_old       <= RESET_PC;
            instr        <= NOP_INSTR;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (pc_load) begin
                pc <= {pc_src[XLEN-1:2], 2'b00};
                if (|pc_src[1:0]) begin
                    misalign_err <= 1'b1;
                end
            end
            if (inst_en) begin
                instr       <= mem_rdata[31:0];
                pc_old      <= pc;
                instr_valid <= 1'b1;
            end
        end
    end

endmodule
